vertex_unpacker: RTL

- Drains the 248-bit triangle record FIFO and serialises each record into per-vertex beats for the downstream rasteriser/setup stage.
- Consumes the FIFO's show-ahead read port: data is valid whenever the FIFO reports not-empty, and a one-cycle read pulse advances it.
- Emits NUM_VERT beats per record over a valid/ready interface.
- Supports back-to-back records with zero bubble cycles.

---
 rtl/vertex_unpacker.sv | 81 ++++++++
 1 files changed

// File: rtl/vertex_unpacker.sv
// Serialises show-ahead FIFO triangle records into one valid/ready beat per vertex.
// The next record is popped on the last-beat transfer so back-to-back records have no bubble.
module vertex_unpacker #(
   parameter int VERT_W   = 80,
   parameter int TAG_W    = 8,
   parameter int NUM_VERT = 3,
   parameter int WIDTH    = TAG_W + NUM_VERT * VERT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            i_fifo_data,
   input  logic                        i_fifo_empty,
   output logic                        o_fifo_read,
   input  logic                        i_flush,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [VERT_W-1:0]           o_vertex,
   output logic [TAG_W-1:0]            o_tag,
   output logic [$clog2(NUM_VERT)-1:0] o_idx,
   output logic                        o_last,
   output logic                        o_busy
);
   localparam int IDX_W = $clog2(NUM_VERT);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   record_q, record_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               xfer;

   assign o_valid = (state_q == EMIT);
   assign o_busy  = o_valid;
   assign o_idx   = idx_q;
   assign o_tag   = record_q[WIDTH-1 -: TAG_W];
   assign o_last  = o_valid && (idx_q == IDX_W'(NUM_VERT - 1));
   assign xfer    = o_valid && i_ready;

   assign o_fifo_read = !rst && !i_fifo_empty && !i_flush &&
                        ((state_q == IDLE) || (xfer && o_last));

   always_comb begin
      o_vertex = '0;
      for (int k = 0; k < NUM_VERT; k++)
         if (idx_q == IDX_W'(k)) o_vertex = record_q[k*VERT_W +: VERT_W];
   end

   // Flush outranks everything; a pop always restarts at vertex 0.
   always_comb begin
      state_d  = state_q;
      record_d = record_q;
      idx_d    = idx_q;
      if (i_flush) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (o_fifo_read) begin
         state_d  = EMIT;
         record_d = i_fifo_data;
         idx_d    = '0;
      end else if (xfer) begin
         if (o_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         record_q <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         record_q <= record_d;
         idx_q    <= idx_d;
      end
   end
endmodule
